// File: rtl/regwrite_arbiter_pkg.sv
// Shared widths and the CGRA result FIFO entry format for the register-file write arbiter.
package regwrite_arbiter_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned POS_W  = 4;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
        logic [POS_W-1:0]  pos;
    } fifo_entry_t;

endpackage

// File: rtl/regwrite_fifo.sv
// Circular buffer of CGRA results with per-entry valid bits, address squash and address lookup.
module regwrite_fifo
    import regwrite_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              push_i,
    input  fifo_entry_t       push_entry_i,
    input  logic              pop_i,
    input  logic              squash_i,
    input  logic [REG_AW-1:0] squash_addr_i,
    input  logic [REG_AW-1:0] chk_addr_i,
    output logic              chk_hit_o,
    output fifo_entry_t       head_o,
    output logic              head_occ_o,
    output logic              full_o,
    output logic [3:0]        count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    fifo_entry_t       mem_q [DEPTH];
    fifo_entry_t       mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    // Slot occupancy, including squashed slots still waiting to be dropped at the head.
    logic [CW-1:0]     used_q, used_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (squash_i && mem_q[i].addr == squash_addr_i) begin
                mem_d[i].valid = 1'b0;
            end
        end
        if (pop_i) begin
            mem_d[rd_ptr_q].valid = 1'b0;
        end
        // Written after the squash so a same-cycle CPU write cannot kill the newer result.
        if (push_i) begin
            mem_d[wr_ptr_q]       = push_entry_i;
            mem_d[wr_ptr_q].valid = 1'b1;
        end
        used_d = used_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            used_q <= used_d;
        end
    end

    always_comb begin
        count_o   = '0;
        chk_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            count_o = count_o + {3'b000, mem_q[i].valid};
            if (mem_q[i].valid && mem_q[i].addr == chk_addr_i) begin
                chk_hit_o = 1'b1;
            end
        end
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign head_occ_o = (used_q != '0);
    assign full_o     = (used_q >= DepthC);

endmodule

// File: rtl/regwrite_arbiter.sv
// Merges CPU writeback and queued CGRA results onto one registered register-file write port.
module regwrite_arbiter
    import regwrite_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned STARVE = 4
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic [POS_W-1:0]  wb_pos_i,
    input  logic              cgra_valid_i,
    output logic              cgra_ready_o,
    input  logic [REG_AW-1:0] cgra_addr_i,
    input  logic [XLEN-1:0]   cgra_data_i,
    input  logic [POS_W-1:0]  cgra_pos_i,
    input  logic [REG_AW-1:0] chk_addr_i,
    output logic              pending_hit_o,
    output logic              RegWrite_o,
    output logic [REG_AW-1:0] RDaddr_o,
    output logic [XLEN-1:0]   RDdata_o,
    output logic [POS_W-1:0]  is_pos_o,
    output logic [3:0]        fifo_count_o,
    output logic              cpu_stall_o
);

    localparam int unsigned SW = $clog2(STARVE + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE);

    fifo_entry_t       push_entry, head;
    logic              cpu_sel, fifo_sel, push, pop, head_occ, head_valid, head_squash;
    logic              full, fifo_hit;
    logic [SW-1:0]     starve_q, starve_d;
    logic              stall_d;
    logic              we_d;
    logic [REG_AW-1:0] addr_d;
    logic [XLEN-1:0]   data_d;
    logic [POS_W-1:0]  pos_d;

    assign cgra_ready_o = !full;
    assign cpu_sel      = wb_we_i && (wb_addr_i != '0);
    // Writes to x0 are handshaken but dropped.
    assign push         = cgra_valid_i && cgra_ready_o && (cgra_addr_i != '0);
    assign push_entry   = '{valid: 1'b1, addr: cgra_addr_i, data: cgra_data_i, pos: cgra_pos_i};
    assign head_valid   = head_occ && head.valid;
    assign fifo_sel     = !cpu_sel && head_valid;
    assign head_squash  = cpu_sel && head_valid && (head.addr == wb_addr_i);
    // Dead head slots are dropped while the port is busy or idle, never costing an issue slot.
    assign pop          = fifo_sel || head_squash || (head_occ && !head.valid);

    assign pending_hit_o = (chk_addr_i != '0) &&
                           (fifo_hit || (push && cgra_addr_i == chk_addr_i));

    regwrite_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .reset_n      (reset_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .squash_i     (cpu_sel),
        .squash_addr_i(wb_addr_i),
        .chk_addr_i   (chk_addr_i),
        .chk_hit_o    (fifo_hit),
        .head_o       (head),
        .head_occ_o   (head_occ),
        .full_o       (full),
        .count_o      (fifo_count_o)
    );

    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_count_o == '0) begin
            starve_d = '0;
        end else if (cpu_sel && starve_q != StarveMax) begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = !cpu_stall_o && (starve_d == StarveMax);

        we_d   = 1'b0;
        addr_d = RDaddr_o;
        data_d = RDdata_o;
        pos_d  = is_pos_o;
        if (cpu_sel) begin
            we_d   = 1'b1;
            addr_d = wb_addr_i;
            data_d = wb_data_i;
            pos_d  = wb_pos_i;
        end else if (fifo_sel) begin
            we_d   = 1'b1;
            addr_d = head.addr;
            data_d = head.data;
            pos_d  = head.pos;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            starve_q    <= '0;
            cpu_stall_o <= 1'b0;
            RegWrite_o  <= 1'b0;
            RDaddr_o    <= '0;
            RDdata_o    <= '0;
            is_pos_o    <= '0;
        end else begin
            starve_q    <= starve_d;
            cpu_stall_o <= stall_d;
            RegWrite_o  <= we_d;
            RDaddr_o    <= addr_d;
            RDdata_o    <= data_d;
            is_pos_o    <= pos_d;
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter with hand-computed expectations.
module tb_regwrite_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [4:0]  wb_addr_i = '0;
    logic [31:0] wb_data_i = '0;
    logic [3:0]  wb_pos_i = '0;
    logic        cgra_valid_i = 1'b0;
    logic        cgra_ready_o;
    logic [4:0]  cgra_addr_i = '0;
    logic [31:0] cgra_data_i = '0;
    logic [3:0]  cgra_pos_i = '0;
    logic [4:0]  chk_addr_i = '0;
    logic        pending_hit_o;
    logic        RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic [3:0]  is_pos_o;
    logic [3:0]  fifo_count_o;
    logic        cpu_stall_o;

    int checks = 0;
    int failures = 0;

    regwrite_arbiter #(
        .DEPTH (4),
        .STARVE(4)
    ) dut (
        .clk_i        (clk_i),
        .reset_n      (reset_n),
        .wb_we_i      (wb_we_i),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i),
        .wb_pos_i     (wb_pos_i),
        .cgra_valid_i (cgra_valid_i),
        .cgra_ready_o (cgra_ready_o),
        .cgra_addr_i  (cgra_addr_i),
        .cgra_data_i  (cgra_data_i),
        .cgra_pos_i   (cgra_pos_i),
        .chk_addr_i   (chk_addr_i),
        .pending_hit_o(pending_hit_o),
        .RegWrite_o   (RegWrite_o),
        .RDaddr_o     (RDaddr_o),
        .RDdata_o     (RDdata_o),
        .is_pos_o     (is_pos_o),
        .fifo_count_o (fifo_count_o),
        .cpu_stall_o  (cpu_stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cpu(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [3:0] p);
        wb_we_i = we; wb_addr_i = a; wb_data_i = d; wb_pos_i = p;
    endtask

    task automatic cgra(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [3:0] p);
        cgra_valid_i = v; cgra_addr_i = a; cgra_data_i = d; cgra_pos_i = p;
    endtask

    initial begin
        #2;
        check_eq("rst_regwrite", {31'b0, RegWrite_o}, 32'd0);
        check_eq("rst_count", {28'b0, fifo_count_o}, 32'd0);
        check_eq("rst_ready", {31'b0, cgra_ready_o}, 32'd1);
        check_eq("rst_stall", {31'b0, cpu_stall_o}, 32'd0);
        #10 reset_n = 1'b1;
        step();

        // Single CGRA result issues two edges after it is offered.
        cgra(1'b1, 5'd5, 32'hAAAA_0001, 4'd3);
        step();
        cgra(1'b0, 5'd0, 32'h0, 4'd0);
        check_eq("push_count", {28'b0, fifo_count_o}, 32'd1);
        step();
        check_eq("push_we", {31'b0, RegWrite_o}, 32'd1);
        check_eq("push_addr", {27'b0, RDaddr_o}, 32'd5);
        check_eq("push_data", RDdata_o, 32'hAAAA_0001);
        check_eq("push_pos", {28'b0, is_pos_o}, 32'd3);
        step();
        check_eq("idle_we", {31'b0, RegWrite_o}, 32'd0);
        check_eq("idle_addr_hold", {27'b0, RDaddr_o}, 32'd5);

        // Fill to DEPTH while CPU writes to x31 keep the port busy.
        for (int i = 0; i < 4; i++) begin
            cgra(1'b1, 5'(10 + i), 32'h100 + i, 4'(i));
            cpu(1'b1, 5'd31, 32'hC0, 4'd0);
            step();
        end
        cgra(1'b0, 5'd0, 32'h0, 4'd0);
        cpu(1'b0, 5'd0, 32'h0, 4'd0);
        check_eq("full_count", {28'b0, fifo_count_o}, 32'd4);
        check_eq("full_ready", {31'b0, cgra_ready_o}, 32'd0);
        check_eq("full_stall", {31'b0, cpu_stall_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("drain_we", {31'b0, RegWrite_o}, 32'd1);
            check_eq("drain_addr", {27'b0, RDaddr_o}, 32'(10 + i));
            check_eq("drain_data", RDdata_o, 32'h100 + i);
            if (i == 0) check_eq("ready_at_3", {31'b0, cgra_ready_o}, 32'd1);
        end
        step();
        check_eq("drained_we", {31'b0, RegWrite_o}, 32'd0);
        check_eq("drained_count", {28'b0, fifo_count_o}, 32'd0);

        // CPU write squashes the queued older result.
        cgra(1'b1, 5'd7, 32'h11, 4'd1);
        step();
        cgra(1'b0, 5'd0, 32'h0, 4'd0);
        chk_addr_i = 5'd7;
        #1;
        check_eq("pending_q7", {31'b0, pending_hit_o}, 32'd1);
        cpu(1'b1, 5'd7, 32'h22, 4'd2);
        step();
        cpu(1'b0, 5'd0, 32'h0, 4'd0);
        check_eq("squash_we", {31'b0, RegWrite_o}, 32'd1);
        check_eq("squash_data", RDdata_o, 32'h22);
        check_eq("squash_count", {28'b0, fifo_count_o}, 32'd0);
        check_eq("squash_pending", {31'b0, pending_hit_o}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("squash_no_issue", {31'b0, RegWrite_o}, 32'd0);
        end

        // Same-cycle push and CPU write to x8: CPU issues first, pushed entry survives.
        cgra(1'b1, 5'd8, 32'h33, 4'd3);
        cpu(1'b1, 5'd8, 32'h44, 4'd4);
        step();
        cgra(1'b0, 5'd0, 32'h0, 4'd0);
        cpu(1'b0, 5'd0, 32'h0, 4'd0);
        check_eq("same_cpu_data", RDdata_o, 32'h44);
        check_eq("same_count", {28'b0, fifo_count_o}, 32'd1);
        step();
        check_eq("same_cgra_we", {31'b0, RegWrite_o}, 32'd1);
        check_eq("same_cgra_data", RDdata_o, 32'h33);
        step();

        // Starvation: four lost cycles raise a one-cycle stall, head issues in it.
        cgra(1'b1, 5'd12, 32'h55, 4'd5);
        step();
        cgra(1'b0, 5'd0, 32'h0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            cpu(1'b1, 5'd9, 32'h99, 4'd0);
            step();
            check_eq("starve_stall", {31'b0, cpu_stall_o}, (i == 3) ? 32'd1 : 32'd0);
            check_eq("starve_cpu_addr", {27'b0, RDaddr_o}, 32'd9);
        end
        cpu(1'b0, 5'd0, 32'h0, 4'd0);
        step();
        check_eq("stall_issue_addr", {27'b0, RDaddr_o}, 32'd12);
        check_eq("stall_issue_data", RDdata_o, 32'h55);
        check_eq("stall_release", {31'b0, cpu_stall_o}, 32'd0);
        check_eq("stall_count", {28'b0, fifo_count_o}, 32'd0);

        // x0 on both sides is dropped.
        cpu(1'b1, 5'd0, 32'hDEAD, 4'd1);
        cgra(1'b1, 5'd0, 32'hBEEF, 4'd2);
        chk_addr_i = 5'd0;
        #1;
        check_eq("x0_pending", {31'b0, pending_hit_o}, 32'd0);
        step();
        cpu(1'b0, 5'd0, 32'h0, 4'd0);
        cgra(1'b0, 5'd0, 32'h0, 4'd0);
        check_eq("x0_we", {31'b0, RegWrite_o}, 32'd0);
        check_eq("x0_count", {28'b0, fifo_count_o}, 32'd0);

        // Lookup sees the entry being pushed this cycle.
        cgra(1'b1, 5'd6, 32'h66, 4'd6);
        chk_addr_i = 5'd6;
        #1;
        check_eq("push_pending", {31'b0, pending_hit_o}, 32'd1);
        cgra(1'b0, 5'd0, 32'h0, 4'd0);
        chk_addr_i = 5'd0;
        step();
        step();

        // Reset with three queued entries.
        for (int i = 0; i < 3; i++) begin
            cgra(1'b1, 5'(20 + i), 32'h200 + i, 4'(i));
            cpu(1'b1, 5'd31, 32'hF00D, 4'd7);
            step();
        end
        cgra(1'b0, 5'd0, 32'h0, 4'd0);
        check_eq("pre_rst_count", {28'b0, fifo_count_o}, 32'd3);
        reset_n = 1'b0;
        cpu(1'b0, 5'd0, 32'h0, 4'd0);
        #1;
        check_eq("rst_mid_we", {31'b0, RegWrite_o}, 32'd0);
        check_eq("rst_mid_addr", {27'b0, RDaddr_o}, 32'd0);
        check_eq("rst_mid_data", RDdata_o, 32'd0);
        check_eq("rst_mid_pos", {28'b0, is_pos_o}, 32'd0);
        check_eq("rst_mid_count", {28'b0, fifo_count_o}, 32'd0);
        #10 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("post_rst_we", {31'b0, RegWrite_o}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
